p405s_itlb_shadow_array: RTL and testbench

P405S_ITLB_SHADOW_ARRAY -- requirements
Module: p405s_itlb_shadow_array

---
 rtl/p405s_itlb_shadow_array.sv | 219 +++++++++++++++++++++
 tb/tb_p405s_itlb_shadow_array.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/p405s_itlb_shadow_array.sv
// p405s_itlb_shadow_array
//   Small fully-associative instruction TLB shadow array.
//   Lookups are two-stage: the request and EA are registered on one CB edge,
//   and the compare/select result is driven combinationally during the next
//   cycle from that stage register and the current entry contents.
//   Fills pick the lowest-index invalid entry, otherwise a round-robin victim.
//
// Ports
//   CB, reset                 clock, asynchronous active-high reset
//   lookupValid, isAbort_N    lookup request / low cancels it
//   msrIrL2                   1 = translate, 0 = real mode (EA passes through)
//   isEA[0:21]                effective page address
//   fillValid/fillReady       fill handshake (ready = ~invalidateAll)
//   fillEPN/DSize/RPN/Attr    fill contents, attr = {I,E,U0}
//   invalidateAll             clear every valid bit
//   Hit, Miss, RA, I/E/U0_out lookup result
//   hitIndex, multiHit        winning entry (lowest index), >1 matches
//   entryValid                per-entry valid bits
//
// Page-offset bit numbering: "EA bit n" in the size mask counts from the
// least significant end (weight 2^n). Size[k] turns EA bits 8+2k and 9+2k
// into page offset; the low byte (bits 0..7) is always compared and always
// sourced from the RPN.

// One shadow entry: storage plus its own masked compare and RA merge.
module p405s_itlb_shadow_entry (
    input  logic        CB,
    input  logic        reset,
    input  logic        we,
    input  logic        clr,
    input  logic [21:0] epn_in,
    input  logic [6:0]  size_in,   // size_in[6-k] = Size[k]
    input  logic [21:0] rpn_in,
    input  logic [2:0]  attr_in,   // {I,E,U0}
    input  logic [21:0] ea,
    output logic        vld,
    output logic        match,
    output logic [21:0] ra,
    output logic [2:0]  attr
);
    logic [21:0] epn_q;
    logic [6:0]  size_q;
    logic [21:0] rpn_q;
    logic [21:0] mask;

    always_ff @(posedge CB or posedge reset) begin
        if (reset)    vld <= 1'b0;
        else if (clr) vld <= 1'b0;
        else if (we)  vld <= 1'b1;
    end

    // Translation contents carry no reset; valid gates all use of them.
    always_ff @(posedge CB) begin
        if (we) begin
            epn_q  <= epn_in;
            size_q <= size_in;
            rpn_q  <= rpn_in;
            attr   <= attr_in;
        end
    end

    always_comb begin
        mask = '0;
        for (int k = 0; k < 7; k++) begin
            mask[8 + 2*k] = size_q[6 - k];
            mask[9 + 2*k] = size_q[6 - k];
        end
    end

    assign match = vld & (((ea ^ epn_q) & ~mask) == 22'd0);
    assign ra    = (rpn_q & ~mask) | (ea & mask);
endmodule

module p405s_itlb_shadow_array #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = 2
) (
    input  logic                   CB,
    input  logic                   reset,
    input  logic                   lookupValid,
    input  logic                   isAbort_N,
    input  logic                   msrIrL2,
    input  logic [0:21]            isEA,
    input  logic                   fillValid,
    output logic                   fillReady,
    input  logic [0:21]            fillEPN,
    input  logic [0:6]             fillDSize,
    input  logic [0:21]            fillRPN,
    input  logic [0:2]             fillAttr,
    input  logic                   invalidateAll,
    output logic                   Hit,
    output logic                   Miss,
    output logic [0:21]            RA,
    output logic                   I_out,
    output logic                   E_out,
    output logic                   U0_out,
    output logic [IDX_W-1:0]       hitIndex,
    output logic                   multiHit,
    output logic [NUM_ENTRIES-1:0] entryValid
);
    typedef struct packed {
        logic        msr;
        logic [21:0] ea;
    } stage_t;

    logic                              req_s1;
    logic                              req_q;
    stage_t                            stg_q;
    logic [NUM_ENTRIES-1:0]            ent_vld;
    logic [NUM_ENTRIES-1:0]            ent_match;
    logic [NUM_ENTRIES-1:0]            fill_we;
    logic [NUM_ENTRIES-1:0][21:0]      ent_ra;
    logic [NUM_ENTRIES-1:0][2:0]       ent_attr;
    logic [IDX_W-1:0]                  rr_ptr;
    logic [IDX_W-1:0]                  victim;
    logic [IDX_W-1:0]                  sel;
    logic                              have_inv;
    logic                              any_match;
    logic                              multi;
    logic                              fill_acc;

    // Stage 1: register request and address.
    assign req_s1 = lookupValid & isAbort_N & ~reset;

    always_ff @(posedge CB or posedge reset) begin
        if (reset) begin
            req_q <= 1'b0;
            stg_q <= '0;
        end else begin
            req_q <= req_s1;
            stg_q <= '{msr: msrIrL2, ea: isEA};
        end
    end

    // Entries. invalidateAll wins over a same-edge fill via fill_acc.
    assign fillReady = ~invalidateAll;
    assign fill_acc  = fillValid & ~invalidateAll;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        assign fill_we[g] = fill_acc & (victim == IDX_W'(g));
        p405s_itlb_shadow_entry u_ent (
            .CB      (CB),
            .reset   (reset),
            .we      (fill_we[g]),
            .clr     (invalidateAll),
            .epn_in  (fillEPN),
            .size_in (fillDSize),
            .rpn_in  (fillRPN),
            .attr_in (fillAttr),
            .ea      (stg_q.ea),
            .vld     (ent_vld[g]),
            .match   (ent_match[g]),
            .ra      (ent_ra[g]),
            .attr    (ent_attr[g])
        );
    end

    assign entryValid = ent_vld;

    // Victim: lowest invalid entry, else the round-robin pointer.
    always_comb begin
        have_inv = 1'b0;
        victim   = rr_ptr;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!ent_vld[i] && !have_inv) begin
                have_inv = 1'b1;
                victim   = IDX_W'(i);
            end
        end
    end

    // Pointer only moves when it actually chose the victim.
    always_ff @(posedge CB or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (fill_acc && !have_inv)
            rr_ptr <= (rr_ptr == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
    end

    // Stage 2: lowest matching index wins; flag a second match.
    always_comb begin
        any_match = 1'b0;
        multi     = 1'b0;
        sel       = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_match[i]) begin
                if (any_match) multi = 1'b1;
                else begin
                    any_match = 1'b1;
                    sel       = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        Hit                    = 1'b0;
        Miss                   = 1'b0;
        RA                     = '0;
        {I_out, E_out, U0_out} = 3'b000;
        hitIndex               = '0;
        multiHit               = 1'b0;
        if (req_q) begin
            if (!stg_q.msr) begin
                // Real mode: EA passes straight through.
                Hit = 1'b1;
                RA  = stg_q.ea;
            end else if (any_match) begin
                Hit                    = 1'b1;
                RA                     = ent_ra[sel];
                {I_out, E_out, U0_out} = ent_attr[sel];
                hitIndex               = sel;
                multiHit               = multi;
            end else begin
                Miss = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_p405s_itlb_shadow_array.sv
module tb_p405s_itlb_shadow_array;
    logic        CB = 1'b0;
    logic        reset = 1'b1;
    logic        lookupValid = 1'b0, isAbort_N = 1'b1, msrIrL2 = 1'b1;
    logic [21:0] isEA = '0;
    logic        fillValid = 1'b0, fillReady;
    logic [21:0] fillEPN = '0, fillRPN = '0;
    logic [6:0]  fillDSize = '0;
    logic [2:0]  fillAttr = '0;
    logic        invalidateAll = 1'b0;
    logic        Hit, Miss, I_out, E_out, U0_out, multiHit;
    logic [21:0] RA;
    logic [1:0]  hitIndex;
    logic [3:0]  entryValid;

    int checks = 0;
    int errors = 0;

    p405s_itlb_shadow_array #(.NUM_ENTRIES(4), .IDX_W(2)) dut (
        .CB(CB), .reset(reset), .lookupValid(lookupValid), .isAbort_N(isAbort_N),
        .msrIrL2(msrIrL2), .isEA(isEA), .fillValid(fillValid), .fillReady(fillReady),
        .fillEPN(fillEPN), .fillDSize(fillDSize), .fillRPN(fillRPN), .fillAttr(fillAttr),
        .invalidateAll(invalidateAll), .Hit(Hit), .Miss(Miss), .RA(RA),
        .I_out(I_out), .E_out(E_out), .U0_out(U0_out), .hitIndex(hitIndex),
        .multiHit(multiHit), .entryValid(entryValid)
    );

    always #5 CB = ~CB;

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic do_fill(input logic [21:0] epn, input logic [6:0] sz,
                           input logic [21:0] rpn, input logic [2:0] attr);
        fillValid = 1'b1; fillEPN = epn; fillDSize = sz; fillRPN = rpn; fillAttr = attr;
        tick();
        fillValid = 1'b0;
    endtask

    // Leaves the DUT in the stage-2 cycle of this lookup.
    task automatic do_lookup(input logic [21:0] ea, input logic msr, input logic abort_n);
        lookupValid = 1'b1; isEA = ea; msrIrL2 = msr; isAbort_N = abort_n;
        tick();
        lookupValid = 1'b0; msrIrL2 = 1'b1; isAbort_N = 1'b1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (Hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", Hit); end
        checks++; if (Miss !== 1'b0) begin errors++; $display("FAIL rst_miss got %b exp 0", Miss); end
        checks++; if (RA !== 22'h0) begin errors++; $display("FAIL rst_ra got %h exp 0", RA); end
        checks++; if (entryValid !== 4'b0000) begin errors++; $display("FAIL rst_valid got %b exp 0000", entryValid); end
        checks++; if (fillReady !== 1'b1) begin errors++; $display("FAIL rst_fillready got %b exp 1", fillReady); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_fill(22'h0ABCD, 7'b0, 22'h12345, 3'b101);
        checks++; if (entryValid !== 4'b0001) begin errors++; $display("FAIL basic_valid got %b exp 0001", entryValid); end
        do_lookup(22'h0ABCD, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b10) begin errors++; $display("FAIL basic_hitmiss got %b exp 10", {Hit, Miss}); end
        checks++; if (RA !== 22'h12345) begin errors++; $display("FAIL basic_ra got %h exp 12345", RA); end
        checks++; if ({I_out, E_out, U0_out} !== 3'b101) begin errors++; $display("FAIL basic_attr got %b exp 101", {I_out, E_out, U0_out}); end
        checks++; if ({hitIndex, multiHit} !== 3'b000) begin errors++; $display("FAIL basic_idx got %b exp 000", {hitIndex, multiHit}); end
        do_lookup(22'h0ABCE, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL basic_miss got %b exp 01", {Hit, Miss}); end
    endtask

    task automatic test_size();
        do_fill(22'h00000, 7'b1000000, 22'h3FC000, 3'b010);
        checks++; if (entryValid !== 4'b0011) begin errors++; $display("FAIL size_valid got %b exp 0011", entryValid); end
        do_lookup(22'h000300, 1'b1, 1'b1);
        checks++; if (Hit !== 1'b1) begin errors++; $display("FAIL size_hit got %b exp 1", Hit); end
        checks++; if (RA !== 22'h3FC300) begin errors++; $display("FAIL size_ra got %h exp 3fc300", RA); end
        checks++; if (hitIndex !== 2'd1) begin errors++; $display("FAIL size_idx got %0d exp 1", hitIndex); end
        do_lookup(22'h001300, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL size_nomask got %b exp 01", {Hit, Miss}); end
    endtask

    task automatic test_round_robin();
        reset_pulse();
        do_fill(22'h100, 7'b0, 22'h200, 3'b0);
        checks++; if (entryValid !== 4'b0001) begin errors++; $display("FAIL rr_v0 got %b exp 0001", entryValid); end
        do_fill(22'h101, 7'b0, 22'h201, 3'b0);
        checks++; if (entryValid !== 4'b0011) begin errors++; $display("FAIL rr_v1 got %b exp 0011", entryValid); end
        do_fill(22'h102, 7'b0, 22'h202, 3'b0);
        checks++; if (entryValid !== 4'b0111) begin errors++; $display("FAIL rr_v2 got %b exp 0111", entryValid); end
        do_fill(22'h103, 7'b0, 22'h203, 3'b0);
        checks++; if (entryValid !== 4'b1111) begin errors++; $display("FAIL rr_v3 got %b exp 1111", entryValid); end
        do_fill(22'h104, 7'b0, 22'h204, 3'b0);
        do_lookup(22'h100, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL rr_evict0 got %b exp 01", {Hit, Miss}); end
        do_lookup(22'h104, 1'b1, 1'b1);
        checks++; if ({Hit, hitIndex, RA} !== {1'b1, 2'd0, 22'h204}) begin errors++; $display("FAIL rr_new0 got %b/%0d/%h exp 1/0/204", Hit, hitIndex, RA); end
        do_fill(22'h105, 7'b0, 22'h205, 3'b0);
        do_lookup(22'h101, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL rr_evict1 got %b exp 01", {Hit, Miss}); end
        do_lookup(22'h105, 1'b1, 1'b1);
        checks++; if ({Hit, hitIndex, RA} !== {1'b1, 2'd1, 22'h205}) begin errors++; $display("FAIL rr_new1 got %b/%0d/%h exp 1/1/205", Hit, hitIndex, RA); end
    endtask

    task automatic test_abort_real();
        do_lookup(22'h102, 1'b1, 1'b0);
        checks++; if ({Hit, Miss} !== 2'b00) begin errors++; $display("FAIL abort got %b exp 00", {Hit, Miss}); end
        do_lookup(22'h2AAAA, 1'b0, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b10) begin errors++; $display("FAIL real_hitmiss got %b exp 10", {Hit, Miss}); end
        checks++; if (RA !== 22'h2AAAA) begin errors++; $display("FAIL real_ra got %h exp 2aaaa", RA); end
        checks++; if ({I_out, E_out, U0_out, hitIndex} !== 5'b0) begin errors++; $display("FAIL real_attr got %b exp 00000", {I_out, E_out, U0_out, hitIndex}); end
        tick();
        checks++; if ({Hit, Miss, multiHit, RA} !== 25'b0) begin errors++; $display("FAIL idle got %b%b%b/%h exp 000/0", Hit, Miss, multiHit, RA); end
    endtask

    task automatic test_invalidate();
        do_lookup(22'h105, 1'b1, 1'b1);
        invalidateAll = 1'b1;
        fillValid = 1'b1; fillEPN = 22'h155; fillRPN = 22'h255; fillDSize = '0; fillAttr = '0;
        #1;
        checks++; if ({Hit, hitIndex, RA} !== {1'b1, 2'd1, 22'h205}) begin errors++; $display("FAIL inv_prehit got %b/%0d/%h exp 1/1/205", Hit, hitIndex, RA); end
        checks++; if (fillReady !== 1'b0) begin errors++; $display("FAIL inv_ready got %b exp 0", fillReady); end
        tick();
        invalidateAll = 1'b0; fillValid = 1'b0;
        checks++; if (entryValid !== 4'b0000) begin errors++; $display("FAIL inv_valid got %b exp 0000", entryValid); end
        do_lookup(22'h155, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL inv_nofill got %b exp 01", {Hit, Miss}); end
        // rrPtr stayed at 2 through the invalidate.
        do_fill(22'h155, 7'b0, 22'h255, 3'b0);
        do_fill(22'h156, 7'b0, 22'h256, 3'b0);
        do_fill(22'h157, 7'b0, 22'h257, 3'b0);
        do_fill(22'h158, 7'b0, 22'h258, 3'b0);
        do_fill(22'h159, 7'b0, 22'h259, 3'b0);
        do_lookup(22'h157, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL inv_rr_evict got %b exp 01", {Hit, Miss}); end
        do_lookup(22'h159, 1'b1, 1'b1);
        checks++; if ({Hit, hitIndex} !== {1'b1, 2'd2}) begin errors++; $display("FAIL inv_rr_idx got %b/%0d exp 1/2", Hit, hitIndex); end
    endtask

    task automatic test_back_to_back();
        lookupValid = 1'b1; isEA = 22'h155;
        tick();
        checks++; if ({Hit, hitIndex, RA} !== {1'b1, 2'd0, 22'h255}) begin errors++; $display("FAIL b2b_0 got %b/%0d/%h exp 1/0/255", Hit, hitIndex, RA); end
        isEA = 22'h158;
        fillValid = 1'b1; fillEPN = 22'h160; fillRPN = 22'h260;
        tick();
        fillValid = 1'b0;
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL b2b_1 got %b exp 01", {Hit, Miss}); end
        isEA = 22'h160;
        tick();
        lookupValid = 1'b0;
        checks++; if ({Hit, hitIndex, RA} !== {1'b1, 2'd3, 22'h260}) begin errors++; $display("FAIL b2b_2 got %b/%0d/%h exp 1/3/260", Hit, hitIndex, RA); end
        tick();
        checks++; if ({Hit, Miss} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {Hit, Miss}); end
    endtask

    task automatic test_multihit_reset();
        reset_pulse();
        do_fill(22'h300, 7'b0, 22'h10, 3'b0);
        do_fill(22'h301, 7'b0, 22'h11, 3'b0);
        do_fill(22'h333, 7'b0, 22'h12, 3'b100);
        do_fill(22'h333, 7'b0, 22'h13, 3'b011);
        do_lookup(22'h333, 1'b1, 1'b1);
        checks++; if ({Hit, hitIndex, multiHit} !== {1'b1, 2'd2, 1'b1}) begin errors++; $display("FAIL multi got %b/%0d/%b exp 1/2/1", Hit, hitIndex, multiHit); end
        checks++; if ({RA, I_out, E_out, U0_out} !== {22'h12, 3'b100}) begin errors++; $display("FAIL multi_ra got %h/%b exp 12/100", RA, {I_out, E_out, U0_out}); end
        // Fill into entry 0 while its old contents are being compared.
        do_lookup(22'h300, 1'b1, 1'b1);
        fillValid = 1'b1; fillEPN = 22'h400; fillRPN = 22'h20;
        #1;
        checks++; if ({Hit, hitIndex, multiHit, RA} !== {1'b1, 2'd0, 1'b0, 22'h10}) begin errors++; $display("FAIL fillcmp got %b/%0d/%b/%h exp 1/0/0/10", Hit, hitIndex, multiHit, RA); end
        tick();
        fillValid = 1'b0;
        do_lookup(22'h300, 1'b1, 1'b1);
        checks++; if ({Hit, Miss} !== 2'b01) begin errors++; $display("FAIL fill_old got %b exp 01", {Hit, Miss}); end
        do_lookup(22'h400, 1'b1, 1'b1);
        checks++; if ({Hit, hitIndex, RA} !== {1'b1, 2'd0, 22'h20}) begin errors++; $display("FAIL fill_new got %b/%0d/%h exp 1/0/20", Hit, hitIndex, RA); end
        do_lookup(22'h301, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        checks++; if ({Hit, Miss} !== 2'b00) begin errors++; $display("FAIL midreset got %b exp 00", {Hit, Miss}); end
        checks++; if (entryValid !== 4'b0000) begin errors++; $display("FAIL midreset_valid got %b exp 0000", entryValid); end
        lookupValid = 1'b1; isEA = 22'h301; msrIrL2 = 1'b0;
        tick();
        reset = 1'b0; lookupValid = 1'b0; msrIrL2 = 1'b1;
        checks++; if ({Hit, Miss} !== 2'b00) begin errors++; $display("FAIL rst_stage1 got %b exp 00", {Hit, Miss}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size();
        test_round_robin();
        test_abort_real();
        test_invalidate();
        test_back_to_back();
        test_multihit_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
